// File: rtl/match_scheduler.sv
// -----------------------------------------------------------------------------
// match_scheduler
//
// Purpose:
//   Shares one keyword-matcher engine between four receive channels. A
//   round-robin arbiter picks a requesting channel, the engine automaton is
//   cleared, and the channel's frame is streamed into the engine one byte per
//   cycle. Frames longer than MAXLEN are cut short: the excess bytes are still
//   consumed from the channel but not forwarded, and the result is flagged as
//   truncated. Once the frame has ended and the engine's final match flag has
//   been collected, a one-cycle result strobe reports the channel, whether any
//   keyword was seen, and whether the frame was truncated.
//
// Parameters:
//   NCH     number of requesting channels (only 4 is supported)
//   MAXLEN  maximum number of bytes forwarded to the engine per frame
//
// Ports:
//   rxcoreclk  in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   ch_req     in   [NCH]    channel i has a frame pending
//   ch_data    in   [8*NCH]  byte of channel i on bits [8i+7:8i]
//   ch_dvld    in   [NCH]    byte of channel i is valid
//   ch_last    in   [NCH]    valid byte of channel i ends its frame
//   ch_ack     out  [NCH]    byte of channel i consumed this cycle
//   eng_data   out  [8]      byte forwarded to the engine
//   eng_dvld   out           eng_data valid
//   eng_rst    out           return the engine automaton to its root state
//   eng_match  in            engine match flag, one cycle after its byte
//   res_valid  out           one-cycle result strobe
//   res_ch     out  [2]      channel the result belongs to
//   res_match  out           at least one keyword found in the frame
//   res_trunc  out           frame exceeded MAXLEN
//   busy       out           scheduler is not idle
// -----------------------------------------------------------------------------
module match_scheduler #(
  parameter int NCH    = 4,
  parameter int MAXLEN = 1518
) (
  input  logic             rxcoreclk,
  input  logic             reset,
  input  logic [NCH-1:0]   ch_req,
  input  logic [8*NCH-1:0] ch_data,
  input  logic [NCH-1:0]   ch_dvld,
  input  logic [NCH-1:0]   ch_last,
  output logic [NCH-1:0]   ch_ack,
  output logic [7:0]       eng_data,
  output logic             eng_dvld,
  output logic             eng_rst,
  input  logic             eng_match,
  output logic             res_valid,
  output logic [1:0]       res_ch,
  output logic             res_match,
  output logic             res_trunc,
  output logic             busy
);

  // The counter has to be able to hold MAXLEN itself.
  localparam int LEN_W = $clog2(MAXLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DISCARD,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               acc_q, acc_d;
  logic               trunc_q, trunc_d;
  logic [1:0]         res_ch_q, res_ch_d;
  logic               res_match_q, res_match_d;
  logic               res_trunc_q, res_trunc_d;

  // Signals of the currently granted channel.
  logic               sel_dvld;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               len_at_max;

  // Round-robin candidate.
  logic               rr_found;
  logic [1:0]         rr_pick;
  logic [1:0]         rr_cand;

  // ---------------------------------------------------------------------------
  // Granted-channel selection
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_dvld   = ch_dvld[grant_q];
    sel_last   = ch_last[grant_q];
    sel_data   = ch_data[{grant_q, 3'b000} +: 8];
    // The byte being accepted now is the one that brings the count to MAXLEN.
    len_at_max = (len_q == LEN_W'(MAXLEN - 1));
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search starts just after the last served channel.
  // The 2-bit add wraps 3->0 naturally; k=4 brings the search back to
  // last_grant itself so a lone requester is always served again.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant_q + 2'(k);
      if (!rr_found && ch_req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      len_q        <= '0;
      acc_q        <= 1'b0;
      trunc_q      <= 1'b0;
      res_ch_q     <= '0;
      res_match_q  <= 1'b0;
      res_trunc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      trunc_q      <= trunc_d;
      res_ch_q     <= res_ch_d;
      res_match_q  <= res_match_d;
      res_trunc_q  <= res_trunc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    acc_d        = acc_q;
    trunc_d      = trunc_q;
    res_ch_d     = res_ch_q;
    res_match_d  = res_match_q;
    res_trunc_d  = res_trunc_q;

    // The engine's flag lags its byte by one cycle, so it keeps being
    // collected through DISCARD and the single DRAIN cycle.
    if (state_q == S_STREAM || state_q == S_DISCARD || state_q == S_DRAIN) begin
      acc_d = acc_q | eng_match;
    end

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        len_d   = '0;
        acc_d   = 1'b0;
        trunc_d = 1'b0;
        state_d = S_STREAM;
      end

      S_STREAM: begin
        // A dropped ch_req is deliberately ignored here: only ch_last ends
        // the frame. A last byte landing exactly on MAXLEN is a normal end.
        if (sel_dvld) begin
          len_d = len_q + LEN_W'(1);
          if (sel_last) begin
            state_d = S_DRAIN;
          end else if (len_at_max) begin
            trunc_d = 1'b1;
            state_d = S_DISCARD;
          end
        end
      end

      S_DISCARD: begin
        if (sel_dvld && sel_last) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Results are loaded here so they are already visible during the
        // REPORT strobe and then hold until the next frame reports.
        res_ch_d    = grant_q;
        res_match_d = acc_q | eng_match;
        res_trunc_d = trunc_q;
        state_d     = S_REPORT;
      end

      S_REPORT: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset is applied combinationally so the outputs are forced to
  // their quiet values during the reset cycle itself, not one edge later.
  // ---------------------------------------------------------------------------
  always_comb begin
    ch_ack    = '0;
    eng_data  = '0;
    eng_dvld  = 1'b0;
    eng_rst   = 1'b1;
    res_valid = 1'b0;
    res_ch    = '0;
    res_match = 1'b0;
    res_trunc = 1'b0;
    busy      = 1'b0;

    if (!reset) begin
      eng_rst   = (state_q == S_CLEAR);
      busy      = (state_q != S_IDLE);
      res_ch    = res_ch_q;
      res_match = res_match_q;
      res_trunc = res_trunc_q;

      case (state_q)
        S_STREAM: begin
          if (sel_dvld) begin
            ch_ack[grant_q] = 1'b1;
            eng_dvld        = 1'b1;
            eng_data        = sel_data;
          end
        end

        S_DISCARD: begin
          ch_ack[grant_q] = sel_dvld;
        end

        S_REPORT: begin
          res_valid = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule
